// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and read-sequencer state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Highest page offset from which four word beats still stay inside one 1 KB page.
  localparam logic [9:0] KB_LAST_INCR4_START = 10'h3F0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  function automatic logic incr4_crosses_1kb(input logic [9:0] page_offset);
    return page_offset > KB_LAST_INCR4_START;
  endfunction

endpackage

// File: rtl/ahb_master_read_ctrl.sv
// AHB-Lite master read sequencer: SINGLE/INCR4 reads, each captured beat becomes
// a one-cycle register-bank write. A bus transfer completes on any posedge with hready=1.
module ahb_master_read_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_dr,
  input  logic              cmd_burst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata,
  output logic [DATA_W-1:0] hrdatax1,
  output logic [1:0]        dr1,
  output logic              read_write,
  output state_t            dbg_state
);

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_haddr, w_haddr;
  logic [1:0]          r_htrans, w_htrans;
  logic [2:0]          r_hburst, w_hburst;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_err, w_err;
  logic                r_rw, w_rw;
  logic [DATA_W-1:0]   r_hrdatax1, w_hrdatax1;
  logic [1:0]          r_dr1, w_dr1;
  logic [1:0]          r_cmd_dr, w_cmd_dr;
  logic                r_burst, w_burst;
  logic [1:0]          r_addr_idx, w_addr_idx;
  logic [1:0]          r_beat_idx, w_beat_idx;
  logic [1:0]          w_last_beat;
  logic                w_reject;

  assign w_last_beat = r_burst ? 2'd3 : 2'd0;
  assign w_reject    = (cmd_addr[1:0] != 2'b00) ||
                       (cmd_burst && incr4_crosses_1kb(cmd_addr[9:0]));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_haddr    <= '0;
      r_htrans   <= HTRANS_IDLE;
      r_hburst   <= HBURST_SINGLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rw       <= 1'b1;
      r_hrdatax1 <= '0;
      r_dr1      <= 2'd0;
      r_cmd_dr   <= 2'd0;
      r_burst    <= 1'b0;
      r_addr_idx <= 2'd0;
      r_beat_idx <= 2'd0;
    end else begin
      r_state    <= w_state;
      r_haddr    <= w_haddr;
      r_htrans   <= w_htrans;
      r_hburst   <= w_hburst;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
      r_rw       <= w_rw;
      r_hrdatax1 <= w_hrdatax1;
      r_dr1      <= w_dr1;
      r_cmd_dr   <= w_cmd_dr;
      r_burst    <= w_burst;
      r_addr_idx <= w_addr_idx;
      r_beat_idx <= w_beat_idx;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_haddr    = r_haddr;
    w_htrans   = r_htrans;
    w_hburst   = r_hburst;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_rw       = 1'b1;
    w_hrdatax1 = r_hrdatax1;
    w_dr1      = r_dr1;
    w_cmd_dr   = r_cmd_dr;
    w_burst    = r_burst;
    w_addr_idx = r_addr_idx;
    w_beat_idx = r_beat_idx;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_reject) begin
            w_state = ST_ERR;
            w_done  = 1'b1;
            w_err   = 1'b1;
          end else begin
            w_state    = ST_ADDR;
            w_haddr    = cmd_addr;
            w_htrans   = HTRANS_NONSEQ;
            w_hburst   = cmd_burst ? HBURST_INCR4 : HBURST_SINGLE;
            w_busy     = 1'b1;
            w_cmd_dr   = cmd_dr;
            w_burst    = cmd_burst;
            w_addr_idx = 2'd0;
            w_beat_idx = 2'd0;
          end
        end
      end

      ST_ADDR: begin
        if (hready) begin
          w_state = ST_DATA;
          if (r_burst) begin
            w_haddr    = r_haddr + ADDR_W'(4);
            w_htrans   = HTRANS_SEQ;
            w_addr_idx = 2'd1;
          end else begin
            w_htrans = HTRANS_IDLE;
          end
        end
      end

      // A data phase is always outstanding here; the next address phase may overlap it.
      ST_DATA: begin
        if (hresp) begin
          w_state  = ST_ERR;
          w_htrans = HTRANS_IDLE;
          w_busy   = 1'b0;
          w_done   = 1'b1;
          w_err    = 1'b1;
        end else if (hready) begin
          w_rw       = 1'b0;
          w_hrdatax1 = hrdata;
          w_dr1      = r_cmd_dr + r_beat_idx;
          w_beat_idx = r_beat_idx + 2'd1;
          if (r_beat_idx == w_last_beat) begin
            w_state  = ST_IDLE;
            w_htrans = HTRANS_IDLE;
            w_busy   = 1'b0;
            w_done   = 1'b1;
          end else if (r_htrans != HTRANS_IDLE) begin
            if (r_addr_idx == 2'd3) begin
              w_htrans = HTRANS_IDLE;
            end else begin
              w_haddr    = r_haddr + ADDR_W'(4);
              w_htrans   = HTRANS_SEQ;
              w_addr_idx = r_addr_idx + 2'd1;
            end
          end
        end
      end

      ST_ERR: begin
        w_state = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // The first ERROR cycle must cancel the pending transfer before the next edge.
  assign htrans     = ((r_state == ST_DATA) && hresp) ? HTRANS_IDLE : r_htrans;
  assign haddr      = r_haddr;
  assign hwrite     = 1'b0;
  assign hsize      = HSIZE_WORD;
  assign hburst     = r_hburst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign hrdatax1   = r_hrdatax1;
  assign dr1        = r_dr1;
  assign read_write = r_rw;
  assign dbg_state  = r_state;

endmodule

// File: doc/ahb_master_read_ctrl.md
# ahb_master_read_ctrl

Master-side AHB-Lite read sequencer feeding the 4-entry master register bank. It accepts a read command, issues a SINGLE or INCR4 read on the bus, and captures each HRDATA beat. Each captured beat is presented to the register bank as a one-cycle write (`hrdatax1`, `dr1`, `read_write`=0). The bank's R0–R3 are loaded straight from slave read data.

## Interface
Parameters:
- `ADDR_W`, 32, bus address width
- `DATA_W`, 32, bus/register data width

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  command valid; sampled only in IDLE
- `cmd_addr`  in  ADDR_W  byte address of first beat
- `cmd_dr`  in  2  destination register of first beat
- `cmd_burst`  in  1  0 = SINGLE, 1 = INCR4
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse at command end
- `err`  out  1  one-cycle pulse coincident with `done` on failure
- `haddr`  out  ADDR_W  AHB address
- `htrans`  out  2  IDLE=00, NONSEQ=10, SEQ=11
- `hwrite`  out  1  constant 0
- `hsize`  out  3  constant 010 (word)
- `hburst`  out  3  000 SINGLE / 011 INCR4
- `hready`  in  1  AHB ready
- `hresp`  in  1  AHB response, 1 = ERROR
- `hrdata`  in  DATA_W  AHB read data
- `hrdatax1`  out  DATA_W  captured beat, to register bank
- `dr1`  out  2  destination register for `hrdatax1`
- `read_write`  out  1  0 = bank writes this cycle, 1 = no write

## Operation
- FSM states: IDLE, ADDR, DATA, ERR.
- **IDLE**
  - `start`=1 with `cmd_addr[1:0]`≠0: go to ERR, no bus transfer.
  - `start`=1 with `cmd_burst`=1 and `cmd_addr[9:0]`>0x3F0 (burst would cross 1 KB): go to ERR, no bus transfer.
  - Otherwise: latch the command and go to ADDR.
- **ADDR** (first address phase)
  - Drive `htrans`=NONSEQ and `haddr`=`cmd_addr`.
  - Hold all outputs while `hready`=0.
  - On `hready`=1, go to DATA.
- **DATA** (INCR4)
  - Beats 2–4 use address +4 each, `htrans`=SEQ.
  - Address phase of beat n+1 overlaps data phase of beat n.
  - After the last address is accepted, `htrans`=IDLE.
- **Beat capture**
  - A beat is captured on an edge where `hready`=1 and `hresp`=0 in its data phase.
  - The next cycle, `hrdatax1`=captured data, `dr1`=(`cmd_dr`+beat index) mod 4, `read_write`=0 for exactly one cycle.
  - Destinations wrap modulo 4: `cmd_dr`=2 with INCR4 loads R2, R3, R0, R1.
- **Error response**
  - First ERROR cycle (`hresp`=1, `hready`=0): drive `htrans`=IDLE that same cycle (combinational from `hresp`), cancelling any pending beat. Go to ERR.
  - The errored beat is never written to the bank.
  - Beats completed before the error remain written.
- **ERR**: pulse `done`=`err`=1 for one cycle, then return to IDLE.
- **Normal completion**: `done` pulses in the same cycle as the last `read_write`=0; `err`=0.
- `start` while `busy` is ignored; there is no queueing.

## Timing
- Reset values: `htrans`=00, `haddr`=0, `hburst`=000, `busy`=0, `done`=0, `err`=0, `read_write`=1, `hrdatax1`=0, `dr1`=0. FSM returns to IDLE.
- `rst` mid-transfer: the next cycle shows reset values. No `done` pulse and no further bank writes occur.
- All outputs are registered except the ERROR-cycle `htrans` override.
- Zero-wait SINGLE:
  - Edge E0 accepts `start`.
  - Cycle after E0: address phase.
  - Cycle after E1: data phase.
  - Edge E2 captures data.
  - Cycle after E2: `read_write`=0 and `done`=1.
  - The bank register updates at E3.
- Zero-wait INCR4: four consecutive `read_write`=0 cycles, the first at E0+2.
- Each `hready`=0 cycle delays every subsequent event by one cycle.
- Early rejects (misaligned or 1 KB crossing): `done`=`err`=1 in the cycle after E0; `htrans` stays IDLE.

## Structure
- Shared package `ahb_pkg` holds:
  - HTRANS, HBURST and HSIZE encodings
  - the FSM state enum
  - the 1 KB boundary constant
- Single module; no sub-module needed. Beat counter and address incrementer are inline.

## Test plan
- SINGLE, `cmd_addr`=0x100, `cmd_dr`=1, `hrdata`=0xDEADBEEF, zero wait → `read_write`=0 with `dr1`=1 and `hrdatax1`=0xDEADBEEF at E0+2; `done`=1, `err`=0.
- INCR4, `cmd_addr`=0x200, `cmd_dr`=2, data 0x11/0x22/0x33/0x44 → `haddr` 0x200/0x204/0x208/0x20C (NONSEQ then SEQ ×3); writes 0x11→R2, 0x22→R3, 0x33→R0, 0x44→R1.
- INCR4 with `hready`=0 for 2 cycles on beat 2 → outputs held; total duration +2 cycles; data order unchanged.
- INCR4 with ERROR response on beat 3 → beats 1–2 written; `htrans`=IDLE in the first ERROR cycle; `done`=`err`=1; no third or fourth write.
- `cmd_addr`=0x3F4 with INCR4, and separately `cmd_addr`=0x102 → immediate `done`=`err`=1; `htrans` never leaves IDLE.
- `rst` asserted during beat 2 of an INCR4 → all outputs at reset values the next cycle; no `done`; a fresh `start` afterwards completes normally.
